// File: rtl/uart_tx_fifo_if.sv
// Byte-push handshake between a producer (core/MMIO) and the UART transmitter FIFO.
// A byte moves on a clock edge where valid and ready are both high.
interface uart_tx_fifo_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a power-of-two byte FIFO; serializes LSB first onto tx_o.
// Frames are sent back-to-back with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
    parameter int unsigned FREQ       = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    uart_tx_fifo_if.slave                 in_if,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned CPS  = FREQ / BAUD;
    localparam int unsigned CntW = (CPS < 2) ? 1 : $clog2(CPS);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    localparam logic [CntW-1:0] CntLast = CntW'(CPS - 1);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

    if (CPS < 2) begin : gen_cps_check
        $error("uart_tx_fifo: FREQ/BAUD must be at least 2");
    end

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gen_depth_check
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   bitcnt_q, bitcnt_d;
    logic [2:0]        bitidx_q, bitidx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [7:0]        head;
    logic              bit_end;

    assign fifo_full  = (level_q == LvlFull);
    assign fifo_empty = (level_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign bit_end    = (bitcnt_q == CntLast);

    // ready depends only on registered level, so a same-cycle pop never reopens a full FIFO.
    assign in_if.ready = !fifo_full;
    assign push        = in_if.valid && !fifo_full;

    assign tx_o         = tx_q;
    assign busy_o       = (state_q != StIdle) || !fifo_empty;
    assign fifo_level_o = level_q;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        bitidx_d = bitidx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = head;
                    tx_d     = 1'b0;
                    bitcnt_d = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    tx_d     = shift_q[0];
                    bitidx_d = '0;
                    bitcnt_d = '0;
                    state_d  = StData;
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    bitcnt_d = '0;
                    if (bitidx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        shift_d  = {1'b0, shift_q[7:1]};
                        tx_d     = shift_q[1];
                        bitidx_d = bitidx_q + 1'b1;
                    end
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    bitcnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            bitcnt_q <= '0;
            bitidx_q <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            bitidx_q <= bitidx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_if.data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CPS=4, depth 8; a serial monitor decodes tx_o frames.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       tx;
    logic       busy;
    logic [3:0] level;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .FREQ       (16),
        .BAUD       (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_if        (bus),
        .tx_o         (tx),
        .busy_o       (busy),
        .fifo_level_o (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Serial monitor: CPS=4, sample each bit in its third cycle.
    logic [7:0] rx_q [$];
    int         frame_err = 0;
    bit         mon_act   = 1'b0;
    int         mon_cnt   = 0;
    logic [7:0] mon_sh    = '0;

    always @(negedge clk) begin
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 2 && tx !== 1'b0) frame_err++;
            if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
                mon_sh = {tx, mon_sh[7:1]};
            if (mon_cnt == 38) begin
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(mon_sh);
            end
            if (mon_cnt == 39) mon_act = 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        bus.valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        frame_err = 0;
    endtask

    task automatic push_byte(input logic [7:0] b, output bit ok);
        ok        = 1'b0;
        bus.data  = b;
        bus.valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (bus.ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.valid = 1'b0;
        bus.data  = 8'h00;
        @(negedge clk);
        n_chk++; if (tx !== 1'b1) $display("FAIL reset_tx got %0b want 1", tx); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
        n_chk++; if (level !== 4'd0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
        n_chk++; if (bus.ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", bus.ready);
                 else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_a5();
        logic [9:0] frame;
        bit         ok;
        int         bad;
        frame = {1'b1, 8'hA5, 1'b0};
        do_reset();
        push_byte(8'hA5, ok);
        n_chk++; if (level !== 4'd1) $display("FAIL a5_level got %0d want 1", level); else n_pass++;
        n_chk++; if (tx !== 1'b1) $display("FAIL a5_pre_tx got %0b want 1", tx); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL a5_busy got %0b want 1", busy); else n_pass++;
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            n_chk++;
            if (tx !== frame[k/4]) begin
                $display("FAIL a5_bit cyc %0d got %0b want %0b", k, tx, frame[k/4]);
                bad++;
            end else n_pass++;
            if (k == 39) begin
                n_chk++; if (busy !== 1'b1) $display("FAIL a5_busy_end got %0b want 1", busy);
                         else n_pass++;
            end
            @(negedge clk);
        end
        n_chk++; if (busy !== 1'b0) $display("FAIL a5_busy_drop got %0b want 0", busy); else n_pass++;
        n_chk++; if (tx !== 1'b1) $display("FAIL a5_idle_tx got %0b want 1", tx); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [19:0] frames;
        bit          ok;
        frames = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
        do_reset();
        push_byte(8'h00, ok);
        push_byte(8'hFF, ok);
        // Second push coincided with the first pop.
        n_chk++; if (level !== 4'd1) $display("FAIL b2b_level got %0d want 1", level); else n_pass++;
        for (int k = 0; k < 80; k++) begin
            n_chk++;
            if (tx !== frames[k/4]) $display("FAIL b2b_bit cyc %0d got %0b want %0b", k, tx,
                                             frames[k/4]);
            else n_pass++;
            if (k == 79) begin
                n_chk++; if (busy !== 1'b1) $display("FAIL b2b_busy_end got %0b want 1", busy);
                         else n_pass++;
            end
            @(negedge clk);
        end
        n_chk++; if (busy !== 1'b0) $display("FAIL b2b_busy_drop got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_fill_order();
        logic [7:0] bytes [12];
        int         idx;
        bit         saw_full;
        bit         ok;
        for (int i = 0; i < 12; i++) bytes[i] = 8'(i * 37 + 5);
        do_reset();
        idx       = 0;
        saw_full  = 1'b0;
        bus.valid = 1'b1;
        for (int c = 0; c < 2000 && idx < 12; c++) begin
            bus.data = bytes[idx];
            if (bus.ready !== 1'b1) begin
                if (!saw_full) begin
                    saw_full = 1'b1;
                    n_chk++; if (level !== 4'd8) $display("FAIL fill_level got %0d want 8", level);
                             else n_pass++;
                end
            end else begin
                idx++;
            end
            @(negedge clk);
        end
        bus.valid = 1'b0;
        n_chk++; if (saw_full !== 1'b1) $display("FAIL fill_ready_drop got %0b want 1", saw_full);
                 else n_pass++;
        n_chk++; if (idx !== 12) $display("FAIL fill_accepted got %0d want 12", idx); else n_pass++;
        wait_rx(12, 800, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL fill_timeout got %0d want 12", rx_q.size());
                 else n_pass++;
        for (int i = 0; i < 12; i++) begin
            if (i < rx_q.size()) begin
                n_chk++;
                if (rx_q[i] !== bytes[i]) $display("FAIL fill_byte %0d got %02h want %02h", i,
                                                   rx_q[i], bytes[i]);
                else n_pass++;
            end
        end
        repeat (60) @(negedge clk);
        n_chk++; if (rx_q.size() !== 12) $display("FAIL fill_count got %0d want 12", rx_q.size());
                 else n_pass++;
        n_chk++; if (frame_err !== 0) $display("FAIL fill_framing got %0d want 0", frame_err);
                 else n_pass++;
    endtask

    task automatic test_push_when_full();
        bit ok;
        do_reset();
        for (int i = 0; i < 9; i++) push_byte(8'(8'h40 + i), ok);
        n_chk++; if (level !== 4'd8) $display("FAIL full_level got %0d want 8", level); else n_pass++;
        n_chk++; if (bus.ready !== 1'b0) $display("FAIL full_ready got %0b want 0", bus.ready);
                 else n_pass++;
        bus.data  = 8'hEE;
        bus.valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.valid = 1'b0;
        n_chk++; if (level !== 4'd8) $display("FAIL full_hold_level got %0d want 8", level);
                 else n_pass++;
        wait_rx(9, 600, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL full_timeout got %0d want 9", rx_q.size());
                 else n_pass++;
        repeat (60) @(negedge clk);
        n_chk++; if (rx_q.size() !== 9) $display("FAIL full_count got %0d want 9", rx_q.size());
                 else n_pass++;
        for (int i = 0; i < 9; i++) begin
            if (i < rx_q.size()) begin
                n_chk++;
                if (rx_q[i] !== 8'(8'h40 + i)) $display("FAIL full_byte %0d got %02h want %02h",
                                                       i, rx_q[i], 8'(8'h40 + i));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        do_reset();
        push_byte(8'h55, ok);
        push_byte(8'h81, ok);
        // Now one cycle into the start bit; data bit 3 covers cycles 16..19 from here.
        repeat (17) @(negedge clk);
        n_chk++; if (tx !== 1'b0) $display("FAIL mid_bit3 got %0b want 0", tx); else n_pass++;
        n_chk++; if (level !== 4'd1) $display("FAIL mid_level got %0d want 1", level); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if (tx !== 1'b1) $display("FAIL mid_rst_tx got %0b want 1", tx); else n_pass++;
        n_chk++; if (level !== 4'd0) $display("FAIL mid_rst_level got %0d want 0", level);
                 else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %0b want 0", busy); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        frame_err = 0;
        push_byte(8'h3C, ok);
        wait_rx(1, 100, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL mid_timeout got %0d want 1", rx_q.size());
                 else n_pass++;
        if (rx_q.size() > 0) begin
            n_chk++; if (rx_q[0] !== 8'h3C) $display("FAIL mid_byte got %02h want 3c", rx_q[0]);
                     else n_pass++;
        end
        repeat (60) @(negedge clk);
        n_chk++; if (rx_q.size() !== 1) $display("FAIL mid_count got %0d want 1", rx_q.size());
                 else n_pass++;
        n_chk++; if (frame_err !== 0) $display("FAIL mid_framing got %0d want 0", frame_err);
                 else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL mid_idle_busy got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_hello();
        logic [7:0] msg [6];
        bit         ok;
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};
        do_reset();
        for (int i = 0; i < 6; i++) push_byte(msg[i], ok);
        wait_rx(6, 400, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL hello_timeout got %0d want 6", rx_q.size());
                 else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) begin
                n_chk++;
                if (rx_q[i] !== msg[i]) $display("FAIL hello_char %0d got %02h want %02h", i,
                                                 rx_q[i], msg[i]);
                else n_pass++;
            end
        end
        repeat (60) @(negedge clk);
        n_chk++; if (rx_q.size() !== 6) $display("FAIL hello_count got %0d want 6", rx_q.size());
                 else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_fill_order();
        test_push_when_full();
        test_reset_mid_frame();
        test_hello();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
